bounce_counter: RTL and testbench

Parametrised up/down sequencing counter driving the board LED bank from the slow divided clock. It generalises the fixed 4-bit idle/up/down sequencer with configurable width, limits, step and endpoint dwell. It adds four run modes (bounce, wrap-up, wrap-down, one-shot) plus pause and stop control. It sits after the clock divider and button conditioning; all control inputs arrive active-high, already inverted at the top level.

---
 rtl/bounce_counter.sv | 194 +++++++++++++++++++
 tb/tb_bounce_counter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bounce_counter.sv
// Up/down sequencing counter for the LED bank: bounce, wrap-up, wrap-down and
// one-shot runs with endpoint dwell, pause and stop control.
module bounce_counter #(
  parameter int WIDTH   = 4,
  parameter int MIN_VAL = 0,
  parameter int MAX_VAL = 2**WIDTH-1,
  parameter int STEP    = 1,
  parameter int DWELL   = 0
) (
  input  logic             div_clk,
  input  logic             rst,
  input  logic             go_i,
  input  logic             stop_i,
  input  logic             pause_i,
  input  logic [1:0]       mode_i,
  output logic [WIDTH-1:0] count_o,
  output logic             dir_o,
  output logic             busy_o,
  output logic             wrap_o,
  output logic             done_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_UP   = 2'd1;
  localparam logic [1:0] ST_DOWN = 2'd2;
  localparam logic [1:0] ST_TURN = 2'd3;

  localparam logic [1:0] MODE_BOUNCE    = 2'd0;
  localparam logic [1:0] MODE_UP_WRAP   = 2'd1;
  localparam logic [1:0] MODE_DOWN_WRAP = 2'd2;
  localparam logic [1:0] MODE_ONE_SHOT  = 2'd3;

  localparam int DW_W = (DWELL > 0) ? $clog2(DWELL + 1) : 1;

  localparam logic [WIDTH-1:0] MIN_C    = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAX_C    = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] STEP_C   = WIDTH'(STEP);
  localparam logic [DW_W-1:0]  DWELL_M1 = (DWELL > 0) ? DW_W'(DWELL - 1) : '0;
  localparam logic             HAS_DWELL = (DWELL > 0);

  logic [1:0]       state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             dir_q, dir_d;
  logic [DW_W-1:0]  dwell_q, dwell_d;
  logic             wrap_q, wrap_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   up_sum;
  logic             up_clamp;
  logic [WIDTH-1:0] up_val;
  logic [WIDTH-1:0] down_room;
  logic             down_clamp;
  logic [WIDTH-1:0] down_val;
  logic             at_max;
  logic             at_min;
  logic             active;

  // Sum carries an extra bit; the down path compares remaining headroom
  // against STEP so the subtraction itself can never wrap below MIN_VAL.
  always_comb begin
    up_sum     = {1'b0, count_q} + {1'b0, STEP_C};
    up_clamp   = (up_sum >= {1'b0, MAX_C});
    up_val     = up_clamp ? MAX_C : up_sum[WIDTH-1:0];
    down_room  = count_q - MIN_C;
    down_clamp = (down_room <= STEP_C);
    down_val   = down_clamp ? MIN_C : (count_q - STEP_C);
    at_max     = (count_q == MAX_C);
    at_min     = (count_q == MIN_C);
    active     = (state_q != ST_IDLE);
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    count_d = count_q;
    dir_d   = dir_q;
    dwell_d = dwell_q;
    wrap_d  = 1'b0;
    done_d  = 1'b0;

    if (active && stop_i) begin
      state_d = ST_IDLE;
    end else if (active && pause_i) begin
      state_d = state_q;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (go_i) begin
            mode_d = mode_i;
            if (mode_i == MODE_DOWN_WRAP) begin
              count_d = MAX_C;
              dir_d   = 1'b1;
              state_d = ST_DOWN;
            end else begin
              count_d = MIN_C;
              dir_d   = 1'b0;
              state_d = ST_UP;
            end
          end
        end

        ST_UP: begin
          if (!at_max) begin
            count_d = up_val;
          end else begin
            case (mode_q)
              MODE_BOUNCE: begin
                if (HAS_DWELL) begin
                  dwell_d = DWELL_M1;
                  state_d = ST_TURN;
                end else begin
                  dir_d   = 1'b1;
                  state_d = ST_DOWN;
                end
              end
              MODE_UP_WRAP: begin
                count_d = MIN_C;
                wrap_d  = 1'b1;
              end
              MODE_ONE_SHOT: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
              end
              default: state_d = ST_IDLE;
            endcase
          end
        end

        ST_DOWN: begin
          if (!at_min) begin
            count_d = down_val;
          end else begin
            case (mode_q)
              MODE_BOUNCE: begin
                if (HAS_DWELL) begin
                  dwell_d = DWELL_M1;
                  state_d = ST_TURN;
                end else begin
                  dir_d   = 1'b0;
                  state_d = ST_UP;
                end
              end
              MODE_DOWN_WRAP: begin
                count_d = MAX_C;
                wrap_d  = 1'b1;
              end
              default: state_d = ST_IDLE;
            endcase
          end
        end

        // dir still names the direction we arrived from until the dwell ends.
        ST_TURN: begin
          if (dwell_q == '0) begin
            state_d = dir_q ? ST_UP : ST_DOWN;
            dir_d   = ~dir_q;
          end else begin
            dwell_d = dwell_q - 1'b1;
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge div_clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_BOUNCE;
      count_q <= MIN_C;
      dir_q   <= 1'b0;
      dwell_q <= '0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      count_q <= count_d;
      dir_q   <= dir_d;
      dwell_q <= dwell_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
    end
  end

  assign count_o = count_q;
  assign dir_o   = dir_q;
  assign busy_o  = (state_q != ST_IDLE);
  assign wrap_o  = wrap_q;
  assign done_o  = done_q;

endmodule

// File: tb/tb_bounce_counter.sv
// Directed bench for bounce_counter: defaults, a dwell variant and a
// clamped-range variant share one set of control inputs.
module tb_bounce_counter;

  logic       div_clk;
  logic       rst;
  logic       go;
  logic       stop;
  logic       pause;
  logic [1:0] mode;

  logic [3:0] d_count, w_count, c_count;
  logic       d_dir, w_dir, c_dir;
  logic       d_busy, w_busy, c_busy;
  logic       d_wrap, w_wrap, c_wrap;
  logic       d_done, w_done, c_done;

  int n_checks;
  int n_pass;

  bounce_counter u_def (
    .div_clk(div_clk), .rst(rst), .go_i(go), .stop_i(stop), .pause_i(pause),
    .mode_i(mode), .count_o(d_count), .dir_o(d_dir), .busy_o(d_busy),
    .wrap_o(d_wrap), .done_o(d_done)
  );

  bounce_counter #(.DWELL(3)) u_dw (
    .div_clk(div_clk), .rst(rst), .go_i(go), .stop_i(stop), .pause_i(pause),
    .mode_i(mode), .count_o(w_count), .dir_o(w_dir), .busy_o(w_busy),
    .wrap_o(w_wrap), .done_o(w_done)
  );

  bounce_counter #(.MIN_VAL(2), .MAX_VAL(13), .STEP(4)) u_cl (
    .div_clk(div_clk), .rst(rst), .go_i(go), .stop_i(stop), .pause_i(pause),
    .mode_i(mode), .count_o(c_count), .dir_o(c_dir), .busy_o(c_busy),
    .wrap_o(c_wrap), .done_o(c_done)
  );

  initial div_clk = 1'b0;
  always #5 div_clk = ~div_clk;

  task automatic tick();
    @(posedge div_clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge div_clk);
    go = 1'b0; stop = 1'b0; pause = 1'b0; mode = 2'd0;
    rst = 1'b1;
    #1;
    rst = 1'b0;
    tick();
  endtask

  task automatic start_run(input logic [1:0] m);
    mode = m;
    go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_checks += 6;
    if (d_count !== 4'd0) $display("FAIL reset_count got %0d expected 0", d_count); else n_pass++;
    if (d_dir !== 1'b0) $display("FAIL reset_dir got %0b expected 0", d_dir); else n_pass++;
    if (d_busy !== 1'b0) $display("FAIL reset_busy got %0b expected 0", d_busy); else n_pass++;
    if (d_wrap !== 1'b0) $display("FAIL reset_wrap got %0b expected 0", d_wrap); else n_pass++;
    if (d_done !== 1'b0) $display("FAIL reset_done got %0b expected 0", d_done); else n_pass++;
    if (c_count !== 4'd2) $display("FAIL reset_min_count got %0d expected 2", c_count); else n_pass++;
    rst = 1'b0;
    tick();
    $display("test_reset: complete");
  endtask

  task automatic test_bounce();
    int  exp_c[$];
    bit  exp_d[$];
    for (int v = 0; v <= 15; v++) begin exp_c.push_back(v); exp_d.push_back(1'b0); end
    exp_c.push_back(15); exp_d.push_back(1'b1);
    for (int v = 14; v >= 0; v--) begin exp_c.push_back(v); exp_d.push_back(1'b1); end
    exp_c.push_back(0); exp_d.push_back(1'b0);
    exp_c.push_back(1); exp_d.push_back(1'b0);
    do_reset();
    start_run(2'd0);
    for (int i = 0; i < exp_c.size(); i++) begin
      if (i > 0) tick();
      n_checks += 3;
      if (d_count !== 4'(exp_c[i])) $display("FAIL bounce_count[%0d] got %0d expected %0d", i, d_count, exp_c[i]); else n_pass++;
      if (d_dir !== exp_d[i]) $display("FAIL bounce_dir[%0d] got %0b expected %0b", i, d_dir, exp_d[i]); else n_pass++;
      if (d_busy !== 1'b1 || d_wrap !== 1'b0) $display("FAIL bounce_busy_wrap[%0d] got %0b%0b expected 10", i, d_busy, d_wrap); else n_pass++;
    end
    $display("test_bounce: %0d ticks", exp_c.size());
  endtask

  task automatic test_dwell();
    int exp_c[$];
    for (int pass = 0; pass < 2; pass++) begin
      exp_c.delete();
      for (int v = 0; v <= 15; v++) exp_c.push_back(v);
      for (int k = 0; k < ((pass == 0) ? 4 : 8); k++) exp_c.push_back(15);
      exp_c.push_back(14);
      do_reset();
      start_run(2'd0);
      for (int i = 0; i < exp_c.size(); i++) begin
        if (i > 0) tick();
        n_checks++;
        if (w_count !== 4'(exp_c[i])) $display("FAIL dwell%0d_count[%0d] got %0d expected %0d", pass, i, w_count, exp_c[i]); else n_pass++;
        if (pass == 1 && i == 16) pause = 1'b1;
        if (pass == 1 && i == 20) pause = 1'b0;
      end
      $display("test_dwell: pass %0d, %0d ticks", pass, exp_c.size());
    end
  endtask

  task automatic test_wrap();
    int up_c[9]   = '{2, 6, 10, 13, 2, 6, 10, 13, 2};
    int down_c[6] = '{13, 9, 5, 2, 13, 9};
    do_reset();
    start_run(2'd1);
    for (int i = 0; i < 9; i++) begin
      if (i > 0) tick();
      n_checks += 2;
      if (c_count !== 4'(up_c[i])) $display("FAIL upwrap_count[%0d] got %0d expected %0d", i, c_count, up_c[i]); else n_pass++;
      if (c_wrap !== ((i == 4) || (i == 8))) $display("FAIL upwrap_pulse[%0d] got %0b expected %0b", i, c_wrap, ((i == 4) || (i == 8))); else n_pass++;
    end
    do_reset();
    start_run(2'd2);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick();
      n_checks += 3;
      if (c_count !== 4'(down_c[i])) $display("FAIL downwrap_count[%0d] got %0d expected %0d", i, c_count, down_c[i]); else n_pass++;
      if (c_wrap !== (i == 4)) $display("FAIL downwrap_pulse[%0d] got %0b expected %0b", i, c_wrap, (i == 4)); else n_pass++;
      if (c_dir !== 1'b1) $display("FAIL downwrap_dir[%0d] got %0b expected 1", i, c_dir); else n_pass++;
    end
    $display("test_wrap: up and down runs complete");
  endtask

  task automatic test_one_shot();
    do_reset();
    start_run(2'd3);
    for (int i = 0; i <= 17; i++) begin
      if (i > 0) tick();
      n_checks += 3;
      if (d_count !== ((i <= 15) ? 4'(i) : 4'd15)) $display("FAIL oneshot_count[%0d] got %0d expected %0d", i, d_count, (i <= 15) ? i : 15); else n_pass++;
      if (d_done !== (i == 16)) $display("FAIL oneshot_done[%0d] got %0b expected %0b", i, d_done, (i == 16)); else n_pass++;
      if (d_busy !== (i <= 15)) $display("FAIL oneshot_busy[%0d] got %0b expected %0b", i, d_busy, (i <= 15)); else n_pass++;
    end
    start_run(2'd3);
    n_checks += 2;
    if (d_count !== 4'd0) $display("FAIL oneshot_restart_count got %0d expected 0", d_count); else n_pass++;
    if (d_busy !== 1'b1) $display("FAIL oneshot_restart_busy got %0b expected 1", d_busy); else n_pass++;
    $display("test_one_shot: complete");
  endtask

  task automatic test_stop();
    do_reset();
    start_run(2'd0);
    for (int i = 1; i <= 24; i++) tick();
    n_checks++;
    if (d_count !== 4'd7) $display("FAIL stop_precount got %0d expected 7", d_count); else n_pass++;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    n_checks += 4;
    if (d_count !== 4'd7) $display("FAIL stop_count got %0d expected 7", d_count); else n_pass++;
    if (d_dir !== 1'b1) $display("FAIL stop_dir got %0b expected 1", d_dir); else n_pass++;
    if (d_busy !== 1'b0) $display("FAIL stop_busy got %0b expected 0", d_busy); else n_pass++;
    if (d_done !== 1'b0) $display("FAIL stop_done got %0b expected 0", d_done); else n_pass++;

    start_run(2'd0);
    for (int i = 1; i <= 3; i++) tick();
    stop = 1'b1;
    pause = 1'b1;
    tick();
    stop = 1'b0;
    pause = 1'b0;
    n_checks += 2;
    if (d_busy !== 1'b0) $display("FAIL stoppause_busy got %0b expected 0", d_busy); else n_pass++;
    if (d_count !== 4'd3) $display("FAIL stoppause_count got %0d expected 3", d_count); else n_pass++;
    tick();
    n_checks++;
    if (d_count !== 4'd3) $display("FAIL idle_hold_count got %0d expected 3", d_count); else n_pass++;

    start_run(2'd0);
    for (int i = 1; i <= 5; i++) tick();
    mode = 2'd2;
    go = 1'b1;
    tick();
    n_checks++;
    if (d_count !== 4'd6) $display("FAIL gobusy_count1 got %0d expected 6", d_count); else n_pass++;
    tick();
    go = 1'b0;
    n_checks += 3;
    if (d_count !== 4'd7) $display("FAIL gobusy_count2 got %0d expected 7", d_count); else n_pass++;
    if (d_dir !== 1'b0) $display("FAIL gobusy_dir got %0b expected 0", d_dir); else n_pass++;
    if (d_busy !== 1'b1) $display("FAIL gobusy_busy got %0b expected 1", d_busy); else n_pass++;
    $display("test_stop: complete");
  endtask

  task automatic test_async_reset();
    do_reset();
    start_run(2'd0);
    for (int i = 1; i <= 9; i++) tick();
    n_checks++;
    if (d_count !== 4'd9) $display("FAIL arst_precount got %0d expected 9", d_count); else n_pass++;
    #2;
    rst = 1'b1;
    #1;
    n_checks += 3;
    if (d_count !== 4'd0) $display("FAIL arst_count got %0d expected 0", d_count); else n_pass++;
    if (d_dir !== 1'b0) $display("FAIL arst_dir got %0b expected 0", d_dir); else n_pass++;
    if (d_busy !== 1'b0) $display("FAIL arst_busy got %0b expected 0", d_busy); else n_pass++;
    #1;
    rst = 1'b0;
    start_run(2'd2);
    n_checks += 3;
    if (d_count !== 4'd15) $display("FAIL arst_down_count got %0d expected 15", d_count); else n_pass++;
    if (d_dir !== 1'b1) $display("FAIL arst_down_dir got %0b expected 1", d_dir); else n_pass++;
    if (d_busy !== 1'b1) $display("FAIL arst_down_busy got %0b expected 1", d_busy); else n_pass++;
    $display("test_async_reset: complete");
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst   = 1'b1;
    go    = 1'b0;
    stop  = 1'b0;
    pause = 1'b0;
    mode  = 2'd0;
    test_reset();
    test_bounce();
    test_dwell();
    test_wrap();
    test_one_shot();
    test_stop();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
